// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the PC fetch stage.
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHold,
    StDrain
  } fetch_state_e;

  localparam logic [31:0]        RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned        INSTR_W          = 32;
  localparam logic [INSTR_W-1:0] INSTR_NOP        = 32'h0000_0013;

endpackage

// File: rtl/pc_next_sel.sv
// Redirect priority mux (jump over branch) with target alignment handling.
// PC_ALIGN_CHECK_EN: reject misaligned targets and flag them; otherwise force word alignment.
module pc_next_sel
  import pc_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_target,
  output logic              redirect,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              misalign
);

  logic              req;
  logic [ADDR_W-1:0] sel;

  always_comb begin
    req = jump_en | branch_taken;
    sel = jump_en ? jump_target : branch_target;
`ifdef PC_ALIGN_CHECK_EN
    misalign    = req && (sel[1:0] != 2'b00);
    redirect    = req && !misalign;
    redirect_pc = sel;
`else
    misalign    = 1'b0;
    redirect    = req;
    redirect_pc = sel & ~ADDR_W'(3);
`endif
  end

endmodule

// File: rtl/pc_fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, redirect handling, held output.
// Optional PC_ALIGN_CHECK_EN enables the sticky misaligned-redirect flag.
module pc_fetch_stage
  import pc_fetch_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               jump_en,
  input  logic [ADDR_W-1:0]  jump_target,
  input  logic               stall,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [ADDR_W-1:0]  if_pc_plus4,
  output logic               misalign_err
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] if_instr_q, if_instr_d;
  logic [ADDR_W-1:0]  if_pc_q, if_pc_d;
  logic [ADDR_W-1:0]  if_pc_plus4_q, if_pc_plus4_d;
  logic               misalign_q, misalign_d;

  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               misalign;
  logic [ADDR_W-1:0]  pc_plus4;

  pc_next_sel #(
    .ADDR_W(ADDR_W)
  ) u_pc_next_sel (
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump_en      (jump_en),
    .jump_target  (jump_target),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .misalign     (misalign)
  );

  // Wraps modulo 2^ADDR_W by construction.
  assign pc_plus4 = pc_q + ADDR_W'(4);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;
    if_pc_plus4_d = if_pc_plus4_q;
    misalign_d    = misalign_q;
    imem_req      = 1'b0;
    if_valid      = 1'b0;

    // Redirects (and their alignment errors) only count outside IDLE.
    if (state_q != StIdle && misalign) begin
      misalign_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        state_d = StFetch;
      end
      StFetch: begin
        imem_req = 1'b1;
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = imem_ack ? StFetch : StDrain;
        end else if (imem_ack) begin
          if_instr_d    = imem_rdata;
          if_pc_d       = pc_q;
          if_pc_plus4_d = pc_plus4;
          pc_d          = pc_plus4;
          state_d       = StHold;
        end
      end
      StHold: begin
        if_valid = 1'b1;
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = StFetch;
        end else if (if_ready && !stall) begin
          state_d = StFetch;
        end
      end
      StDrain: begin
        // Wait out the abandoned request; its data is dropped.
        if (redirect) begin
          pc_d = redirect_pc;
        end
        if (imem_ack) begin
          state_d = StFetch;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      if_instr_q    <= '0;
      if_pc_q       <= '0;
      if_pc_plus4_q <= '0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
      if_pc_plus4_q <= if_pc_plus4_d;
      misalign_q    <= misalign_d;
    end
  end

  assign imem_addr    = pc_q;
  assign if_instr     = if_instr_q;
  assign if_pc        = if_pc_q;
  assign if_pc_plus4  = if_pc_plus4_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Scoreboard bench for pc_fetch_stage: expected requests/outputs queued by stimulus,
// checked by a memory responder and an output monitor.
module tb_pc_fetch_stage;

  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          branch_taken, jump_en, stall, if_ready;
  logic [AW-1:0] branch_target, jump_target;
  logic          imem_req, imem_ack, if_valid, misalign_err;
  logic [AW-1:0] imem_addr, if_pc, if_pc_plus4;
  logic [31:0]   imem_rdata, if_instr;

  always #5 clk = ~clk;

  pc_fetch_stage #(
    .ADDR_W  (AW),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump_en      (jump_en),
    .jump_target  (jump_target),
    .stall        (stall),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .if_valid     (if_valid),
    .if_ready     (if_ready),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
    .if_pc_plus4  (if_pc_plus4),
    .misalign_err (misalign_err)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
  } out_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_req_q[$];
  out_t        exp_out_q[$];
  int          ack_delay = 2;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'd3) ^ 32'hA5A5_5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_out(input logic [31:0] pc, input logic [31:0] pc4);
    out_t e;
    e.pc    = pc;
    e.instr = word_of(pc);
    e.pc4   = pc4;
    exp_out_q.push_back(e);
  endtask

  // Memory responder: latches a request, acks ack_delay cycles later, checks the address.
  logic        m_busy = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_addr = '0;
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      imem_ack = 1'b0;
      if (m_busy) begin
        m_cnt = m_cnt - 1;
        if (m_cnt <= 0) begin
          imem_ack   = 1'b1;
          imem_rdata = word_of(m_addr);
          m_busy     = 1'b0;
        end
      end else if (imem_req === 1'b1) begin
        m_busy = 1'b1;
        m_cnt  = ack_delay;
        m_addr = imem_addr;
        if (exp_req_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL req_addr: got %h, expected no request", imem_addr);
        end else begin
          chk("req_addr", imem_addr, exp_req_q.pop_front());
        end
      end
    end
  end

  // Output monitor: each new presentation must match the queue and follow an ack.
  logic valid_prev = 1'b0;
  logic ack_prev = 1'b0;
  initial begin
    out_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        valid_prev = 1'b0;
        ack_prev   = 1'b0;
      end else begin
        if (if_valid && !valid_prev) begin
          chk("valid_latency", 32'(ack_prev), 32'd1);
          if (exp_out_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_unexpected: got pc %h instr %h, expected none", if_pc, if_instr);
          end else begin
            e = exp_out_q.pop_front();
            chk("out_pc", if_pc, e.pc);
            chk("out_instr", if_instr, e.instr);
            chk("out_pc_plus4", if_pc_plus4, e.pc4);
          end
        end
        valid_prev = if_valid;
        ack_prev   = imem_ack;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input string name);
    bit found = 1'b0;
    for (int n = 0; n < 60 && !found; n++) begin
      step();
      if (if_valid === 1'b1) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no if_valid, expected if_valid within 60 cycles", name);
    end
  endtask

  task automatic wait_ack(input string name);
    bit found = 1'b0;
    for (int n = 0; n < 60 && !found; n++) begin
      step();
      if (imem_ack === 1'b1) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no imem_ack, expected imem_ack within 60 cycles", name);
    end
  endtask

  task automatic chk_reset_values();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_pc_plus4", if_pc_plus4, 32'd0);
    chk("rst_misalign", 32'(misalign_err), 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    logic [31:0] nxt;
    int          n;
    branch_taken  = 1'b0;
    branch_target = '0;
    jump_en       = 1'b0;
    jump_target   = '0;
    stall         = 1'b0;
    if_ready      = 1'b1;
    #1 rst_n = 1'b0;
    step();
    step();
    chk_reset_values();

    // Sequential fetch 0x0, 0x4, 0x8 with ack two cycles after each request.
    exp_req_q.push_back(32'h0);
    exp_req_q.push_back(32'h4);
    exp_req_q.push_back(32'h8);
    push_out(32'h0, 32'h4);
    push_out(32'h4, 32'h8);
    push_out(32'h8, 32'hC);
    rst_n = 1'b1;
    #1 chk("idle_req", 32'(imem_req), 32'd0);
    step();
    chk("fetch_after_idle", 32'(imem_req), 32'd1);
    n = 0;
    for (int c = 0; c < 100 && n < 3; c++) begin
      step();
      if (if_valid === 1'b1) begin
        n++;
        if (n == 3) if_ready = 1'b0;
      end
    end
    chk("seq_presentations", 32'(n), 32'd3);

    // Held output stays stable while not accepted, and under stall.
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_valid", 32'(if_valid), 32'd1);
      chk("hold_pc", if_pc, 32'h8);
      chk("hold_instr", if_instr, word_of(32'h8));
      chk("hold_req", 32'(imem_req), 32'd0);
    end
    stall    = 1'b1;
    if_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_valid", 32'(if_valid), 32'd1);
      chk("stall_pc", if_pc, 32'h8);
    end

    // Branch before ack: drain the late ack, then fetch the target.
    ack_delay = 3;
    exp_req_q.push_back(32'hC);
    exp_req_q.push_back(32'h100);
    push_out(32'h100, 32'h104);
    stall = 1'b0;
    step();
    if_ready      = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 32'h100;
    step();
    branch_taken = 1'b0;
    chk("drain_req", 32'(imem_req), 32'd0);
    wait_valid("drain");

    // Jump beats branch when both redirect from HOLD.
    jump_en       = 1'b1;
    jump_target   = 32'h200;
    branch_taken  = 1'b1;
    branch_target = 32'h300;
    exp_req_q.push_back(32'h200);
    step();
    jump_en      = 1'b0;
    branch_taken = 1'b0;
    chk("hold_redirect_valid", 32'(if_valid), 32'd0);

    // Redirect coincident with ack: 0x200 data must never be presented.
    wait_ack("coincident");
    branch_taken  = 1'b1;
    branch_target = 32'h300;
    exp_req_q.push_back(32'h300);
    push_out(32'h300, 32'h304);
    step();
    branch_taken = 1'b0;
    chk("coincident_valid", 32'(if_valid), 32'd0);
    wait_valid("after_coincident");

    // Address wrap at the top of the space.
    jump_en     = 1'b1;
    jump_target = 32'hFFFF_FFFC;
    exp_req_q.push_back(32'hFFFF_FFFC);
    push_out(32'hFFFF_FFFC, 32'h0);
    step();
    jump_en = 1'b0;
    wait_valid("wrap");
    exp_req_q.push_back(32'h0);
    push_out(32'h0, 32'h4);
    if_ready = 1'b1;
    step();
    if_ready = 1'b0;
    wait_valid("wrap_next");

    // Misaligned branch target.
    branch_taken  = 1'b1;
    branch_target = 32'h102;
`ifdef PC_ALIGN_CHECK_EN
    step();
    branch_taken = 1'b0;
    chk("misalign_set", 32'(misalign_err), 32'd1);
    chk("misalign_ignored_valid", 32'(if_valid), 32'd1);
    step();
    step();
    chk("misalign_sticky", 32'(misalign_err), 32'd1);
    nxt = 32'h4;
`else
    exp_req_q.push_back(32'h100);
    push_out(32'h100, 32'h104);
    step();
    branch_taken = 1'b0;
    chk("misalign_tied", 32'(misalign_err), 32'd0);
    chk("aligned_redirect_valid", 32'(if_valid), 32'd0);
    wait_valid("aligned_redirect");
    nxt = 32'h104;
`endif

    // Reset during an outstanding request; the stale ack lands in IDLE.
    exp_req_q.push_back(nxt);
    if_ready = 1'b1;
    step();
    if_ready = 1'b0;
    rst_n    = 1'b0;
    step();
    chk_reset_values();
    step();
    step();
    exp_req_q.push_back(32'h0);
    push_out(32'h0, 32'h4);
    rst_n = 1'b1;
    #1 chk("idle_req_after_reset", 32'(imem_req), 32'd0);
    wait_valid("after_reset");
    step();

    chk("req_queue_empty", 32'(exp_req_q.size()), 32'd0);
    chk("out_queue_empty", 32'(exp_out_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
